cnn_sequencer: RTL

//  Top-level controller for the CNN inference datapath. Loads conv/fc weights from a host write stream,

---
 rtl/cnn_pkg.sv | 34 +++
 rtl/cnn_sequencer_if.sv | 27 ++
 rtl/cnn_argmax.sv | 54 +++++
 rtl/cnn_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN inference sequencer.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    FEED,
    WAIT_RES,
    ARGMAX,
    DONE
  } state_t;

  // Which CNN weight memory a host weight word is aimed at.
  typedef enum logic [1:0] {
    TGT_CONV,
    TGT_FC,
    TGT_BAD
  } target_kind_t;

  // Layer indices run conv layers first, then fc layers; anything past that is invalid.
  function automatic target_kind_t decode_target(input logic [7:0] target,
                                                 input int conv_numb,
                                                 input int flat_numb);
    if (int'(target) < conv_numb) return TGT_CONV;
    if (int'(target) < conv_numb + flat_numb) return TGT_FC;
    return TGT_BAD;
  endfunction

  // Index width for a vector of n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_sequencer_if.sv
// Host-side weight-write and pixel streams feeding the CNN sequencer.
interface cnn_sequencer_if #(
  parameter int PIX_WIDTH = 16
);
  logic                 w_valid;
  logic                 w_ready;
  logic [7:0]           w_target;
  logic [31:0]          w_data;
  logic [31:0]          w_addr;
  logic [31:0]          w_sel;
  logic                 w_last;
  logic                 px_valid;
  logic                 px_ready;
  logic [PIX_WIDTH-1:0] px_data;

  // Host side: produces words and pixels.
  modport master (
    output w_valid, w_target, w_data, w_addr, w_sel, w_last, px_valid, px_data,
    input  w_ready, px_ready
  );

  // Sequencer side: consumes words and pixels.
  modport slave (
    input  w_valid, w_target, w_data, w_addr, w_sel, w_last, px_valid, px_data,
    output w_ready, px_ready
  );
endinterface

// File: rtl/cnn_argmax.sv
// Sequential signed argmax: one class compared per cycle over a latched vector.
module cnn_argmax #(
  parameter int CLASSES_QNT = 10,
  parameter int IDX_W       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CLASSES_QNT-1:0][31:0] classes,
  output logic                         last,
  output logic [IDX_W-1:0]             best_idx,
  output logic [31:0]                  best_score
);

  logic [CLASSES_QNT-1:0][31:0] vec;
  logic [IDX_W-1:0]             idx;
  logic                         running;
  logic signed [31:0]           cur;

  assign cur  = vec[idx];
  assign last = running && (idx == IDX_W'(CLASSES_QNT - 1));

  // Capture the class vector when the scan is launched.
  // NOTE: vec is deliberately not reset: it is always written on start before the scan reads it,
  // so a reset would only cost flops on a plain storage array.
  always_ff @(posedge clk) begin
    if (start) vec <= classes;
  end

  // Walk the vector; strict '>' means ties keep the lowest index.
  always_ff @(posedge clk) begin
    if (rst) begin
      running    <= 1'b0;
      idx        <= '0;
      best_idx   <= '0;
      best_score <= '0;
    end else if (start) begin
      running <= 1'b1;
      idx     <= '0;
    end else if (running) begin
      if (idx == '0 || cur > $signed(best_score)) begin
        best_idx   <= idx;
        best_score <= cur;
      end
      if (last) begin
        running <= 1'b0;
        idx     <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnn_sequencer.sv
// Top-level CNN controller: weight load, framed pixel feed, result wait with timeout, argmax.
module cnn_sequencer
  import cnn_pkg::*;
#(
  parameter int PIX_WIDTH   = 16,
  parameter int CONV_NUMB   = 2,
  parameter int FLAT_NUMB   = 2,
  parameter int CLASSES_QNT = 10,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int TIMEOUT_CYC = 65535,
  localparam int CLASS_IDX_W = idx_width(CLASSES_QNT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         load_weights,
  cnn_sequencer_if.slave               host,
  output logic [31:0]                  weights_mem_in_data,
  output logic [31:0]                  weights_mem_in_addr,
  output logic [31:0]                  weights_mem_in_sel_addr,
  output logic [CONV_NUMB-1:0]         weights_mem_in_kernel_wr,
  output logic [FLAT_NUMB-1:0]         weights_mem_in_fc_wr,
  output logic [PIX_WIDTH-1:0]         cnn_data,
  output logic                         cnn_valid,
  output logic                         cnn_sop,
  output logic                         cnn_eop,
  input  logic                         cnn_o_valid,
  input  logic [CLASSES_QNT-1:0][31:0] cnn_classes,
  output logic                         busy,
  output logic                         done,
  output logic [CLASS_IDX_W-1:0]       result_class,
  output logic [31:0]                  result_score,
  output logic                         err_target,
  output logic                         err_timeout
);

  localparam int FRAME_PIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int PIX_CNT_W  = idx_width(FRAME_PIX);
  localparam int WAIT_CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t                state, next_state;
  logic [PIX_CNT_W-1:0]  pix_cnt;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  start_acc, w_acc, px_acc, px_last, timeout, am_start, am_last;
  logic [7:0]            fc_idx;

  assign start_acc = (state == IDLE) && start;
  assign w_acc     = host.w_valid && host.w_ready;
  assign px_acc    = host.px_valid && host.px_ready;
  assign px_last   = (pix_cnt == PIX_CNT_W'(FRAME_PIX - 1));
  assign timeout   = (wait_cnt == WAIT_CNT_W'(TIMEOUT_CYC));
  assign am_start  = (state == WAIT_RES) && cnn_o_valid;
  assign fc_idx    = host.w_target - 8'(CONV_NUMB);

  assign host.w_ready  = (state == LOAD_W);
  assign host.px_ready = (state == FEED);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  // State register.
  // NOTE: every clocked process uses non-blocking '<=' so all registers update from the same
  // pre-edge values; blocking '=' here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode; a result arriving in the timeout cycle takes priority.
  // NOTE: next_state gets its default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = load_weights ? LOAD_W : FEED;
      LOAD_W:   if (w_acc && host.w_last) next_state = FEED;
      FEED:     if (px_acc && px_last) next_state = WAIT_RES;
      WAIT_RES: begin
        if (cnn_o_valid)  next_state = ARGMAX;
        else if (timeout) next_state = DONE;
      end
      ARGMAX:   if (am_last) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Datapath: weight write-out, pixel forwarding with framing, wait counter and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      weights_mem_in_data      <= '0;
      weights_mem_in_addr      <= '0;
      weights_mem_in_sel_addr  <= '0;
      weights_mem_in_kernel_wr <= '0;
      weights_mem_in_fc_wr     <= '0;
      cnn_data                 <= '0;
      cnn_valid                <= 1'b0;
      cnn_sop                  <= 1'b0;
      cnn_eop                  <= 1'b0;
      pix_cnt                  <= '0;
      wait_cnt                 <= '0;
      err_target               <= 1'b0;
      err_timeout              <= 1'b0;
    end else begin
      // Strobes and pixel flags are single-cycle unless re-armed below.
      weights_mem_in_kernel_wr <= '0;
      weights_mem_in_fc_wr     <= '0;
      cnn_valid                <= 1'b0;
      cnn_sop                  <= 1'b0;
      cnn_eop                  <= 1'b0;

      if (start_acc) begin
        err_target  <= 1'b0;
        err_timeout <= 1'b0;
        pix_cnt     <= '0;
      end

      if (w_acc) begin
        weights_mem_in_data     <= host.w_data;
        weights_mem_in_addr     <= host.w_addr;
        weights_mem_in_sel_addr <= host.w_sel;
        case (decode_target(host.w_target, CONV_NUMB, FLAT_NUMB))
          TGT_CONV: weights_mem_in_kernel_wr <= CONV_NUMB'(1) << host.w_target;
          TGT_FC:   weights_mem_in_fc_wr     <= FLAT_NUMB'(1) << fc_idx;
          default:  err_target               <= 1'b1;
        endcase
      end

      if (px_acc) begin
        cnn_data  <= host.px_data;
        cnn_valid <= 1'b1;
        cnn_sop   <= (pix_cnt == '0);
        cnn_eop   <= px_last;
        pix_cnt   <= px_last ? '0 : pix_cnt + 1'b1;
      end

      if (state == WAIT_RES) wait_cnt <= wait_cnt + 1'b1;
      else                   wait_cnt <= '0;

      if ((state == WAIT_RES) && !cnn_o_valid && timeout) err_timeout <= 1'b1;
    end
  end

  cnn_argmax #(
    .CLASSES_QNT (CLASSES_QNT),
    .IDX_W       (CLASS_IDX_W)
  ) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .start      (am_start),
    .classes    (cnn_classes),
    .last       (am_last),
    .best_idx   (result_class),
    .best_score (result_score)
  );

endmodule
